// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus shared by the IF stage and its memory.
//   imem_req    master -> slave  fetch request, held until imem_ack
//   imem_addr   master -> slave  fetch address, stable while imem_req=1
//   imem_ack    slave -> master  imem_rdata valid this cycle (may coincide with req)
//   imem_rdata  slave -> master  fetched instruction word
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// IF-stage producer for the IF/ID pipeline register. Owns the PC, runs the
// instruction-memory request/ack handshake and presents PCF/InstrF/ValidF.
// Redirects from ID take effect after the delay slot has been delivered.
//   clk          clock, rising edge
//   reset        asynchronous, active-low
//   en           IF/ID enable from hazard unit (0 = stall)
//   redir_valid  ID resolved a taken branch/jump this cycle
//   redir_pc     redirect target
//   imem         fetch bus (master side)
//   PCF          PC of the presented instruction
//   InstrF       presented instruction
//   ValidF       PCF/InstrF valid; IF/ID captures when ValidF && en
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                redir_valid,
    input  logic [31:0]         redir_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         PCF,
    output logic [31:0]         InstrF,
    output logic                ValidF
);

    typedef enum logic [1:0] {StBoot, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic        redir_pend_q, redir_pend_d;
    logic        deliver;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            redir_tgt_q  <= '0;
            redir_pend_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            redir_tgt_q  <= redir_tgt_d;
            redir_pend_q <= redir_pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StWait;
            StWait: if (imem.imem_ack && !en) state_d = StHold;
            StHold: if (en) state_d = StWait;
            default: state_d = StBoot;
        endcase
    end

    // Outputs depend only on registered state plus imem_ack/rdata, so neither
    // en nor redir_* can reach imem_req/imem_addr combinationally.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        PCF            = pc_q;
        InstrF         = '0;
        ValidF         = 1'b0;
        unique case (state_q)
            StBoot: begin
            end
            StWait: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    // Zero-cycle bypass of the returning word
                    ValidF = 1'b1;
                    InstrF = imem.imem_rdata;
                end
            end
            StHold: begin
                ValidF = 1'b1;
                InstrF = buf_q;
            end
            default: begin
            end
        endcase
    end

    assign deliver = ValidF && en;

    // PC / buffer / pending-redirect update
    always_comb begin
        pc_d         = pc_q;
        buf_d        = buf_q;
        redir_tgt_d  = redir_tgt_q;
        redir_pend_d = redir_pend_q;

        if (state_q == StWait && imem.imem_ack && !en) begin
            buf_d = imem.imem_rdata;
        end

        if (deliver) begin
            // The delivered word is the delay slot; the redirect applies to the next PC.
            redir_pend_d = 1'b0;
            if (redir_valid) begin
                pc_d = redir_pc;
            end else if (redir_pend_q) begin
                pc_d = redir_tgt_q;
            end else begin
                pc_d = pc_q + 32'(PC_STEP);
            end
        end else if (redir_valid) begin
            // Latest target wins while ID is stalled
            redir_pend_d = 1'b1;
            redir_tgt_d  = redir_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a variable-latency memory responder,
// an architectural model of the delivered instruction stream checked every
// cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        en;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        ValidF;

    int unsigned lat;
    int unsigned cnt;
    int          checks;
    int          errors;

    // Model state
    logic        m_boot;
    logic        m_have;
    logic        m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_tgt;
    logic        e_req;
    logic        e_valid;
    logic [31:0] deliv_q[$];

    fetch_unit_if imem_bus ();

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem        (imem_bus),
        .PCF         (PCF),
        .InstrF      (InstrF),
        .ValidF      (ValidF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    // Memory: ack once the request has waited lat cycles
    assign imem_bus.imem_ack   = imem_bus.imem_req && (cnt >= lat);
    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (imem_bus.imem_req && !imem_bus.imem_ack) cnt <= cnt + 1;
        else cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Architectural model: next PC to deliver, whether a fetched word is
    // waiting for the stalled pipeline, and any pending redirect target.
    always @(negedge clk) begin
        if (!reset) begin
            m_boot = 1'b1;
            m_have = 1'b0;
            m_pend = 1'b0;
            m_pc   = RST_PC;
            m_tgt  = '0;
        end else begin
            e_req   = !m_boot && !m_have;
            e_valid = m_have || (e_req && imem_bus.imem_ack);
            chk("cmp_req", imem_bus.imem_req, e_req);
            chk("cmp_pcf", PCF, m_pc);
            chk("cmp_valid", ValidF, e_valid);
            chk("cmp_instr", InstrF, e_valid ? mem_word(m_pc) : 32'h0);
            if (e_req) chk("cmp_addr", imem_bus.imem_addr, m_pc);
            if (e_valid && en) begin
                deliv_q.push_back(m_pc);
                m_have = 1'b0;
                if (redir_valid) m_pc = redir_pc;
                else if (m_pend) m_pc = m_tgt;
                else m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end else begin
                if (e_valid) m_have = 1'b1;
                if (redir_valid) begin
                    m_pend = 1'b1;
                    m_tgt  = redir_pc;
                end
            end
            m_boot = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_list[$];
        checks      = 0;
        errors      = 0;
        reset       = 1'b0;
        en          = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        lat         = 0;

        // Reset release, boot cycle
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #3;
        chk("boot_req", imem_bus.imem_req, 0);
        chk("boot_valid", ValidF, 0);
        chk("boot_pcf", PCF, 32'h3000);

        // Zero-wait stream
        tick(); #3;
        chk("t1_pcf0", PCF, 32'h3000);
        chk("t1_valid0", ValidF, 1);
        chk("t1_instr0", InstrF, 32'hA5C3_3000);
        tick(); #3 chk("t1_pcf1", PCF, 32'h3004);
        tick(); #3 chk("t1_pcf2", PCF, 32'h3008);

        // Stall on ack: hold 300C
        tick(); en = 1'b0; #3;
        chk("t2_pcf", PCF, 32'h300C);
        chk("t2_valid", ValidF, 1);
        chk("t2_req_wait", imem_bus.imem_req, 1);
        tick(); #3;
        chk("t2_req_hold", imem_bus.imem_req, 0);
        chk("t2_instr_hold", InstrF, 32'hA5C3_300C);
        tick(); #3 chk("t2_pcf_hold", PCF, 32'h300C);
        tick(); en = 1'b1; #3;
        chk("t2_release_valid", ValidF, 1);
        chk("t2_release_req", imem_bus.imem_req, 0);
        tick(); #3;
        chk("t2_next_addr", imem_bus.imem_addr, 32'h3010);
        chk("t2_next_req", imem_bus.imem_req, 1);

        // Redirect while the fetch waits two cycles
        tick(); lat = 2; redir_valid = 1'b1; redir_pc = 32'h3100; #3;
        chk("t3_wait_valid", ValidF, 0);
        chk("t3_wait_pcf", PCF, 32'h3014);
        tick(); redir_valid = 1'b0; #3 chk("t3_wait_valid2", ValidF, 0);
        tick(); #3;
        chk("t3_slot_valid", ValidF, 1);
        chk("t3_slot_pcf", PCF, 32'h3014);
        tick(); lat = 0; #3;
        chk("t3_redir_addr", imem_bus.imem_addr, 32'h3100);

        // Redirect in the same cycle as delivery
        tick(); redir_valid = 1'b1; redir_pc = 32'h3200; #3;
        chk("t4_slot_pcf", PCF, 32'h3104);
        tick(); redir_valid = 1'b0; #3 chk("t4_tgt_pcf", PCF, 32'h3200);
        tick(); #3 chk("t4_no_pend", PCF, 32'h3204);

        // Two redirects while stalled: latest wins
        tick(); en = 1'b0; redir_valid = 1'b1; redir_pc = 32'h3100; #3;
        chk("t5_slot_pcf", PCF, 32'h3208);
        tick(); redir_pc = 32'h3200; #3 chk("t5_hold_req", imem_bus.imem_req, 0);
        tick(); redir_valid = 1'b0; en = 1'b1; #3 chk("t5_slot_valid", ValidF, 1);
        tick(); #3;
        chk("t5_tgt_addr", imem_bus.imem_addr, 32'h3200);
        chk("t5_tgt_pcf", PCF, 32'h3200);

        // Asynchronous reset in the middle of a waiting fetch
        tick(); lat = 3; #3 chk("t6_wait_valid", ValidF, 0);
        tick(); #1 reset = 1'b0; #1;
        chk("t6_rst_req", imem_bus.imem_req, 0);
        chk("t6_rst_addr", imem_bus.imem_addr, 32'h3000);
        chk("t6_rst_pcf", PCF, 32'h3000);
        chk("t6_rst_instr", InstrF, 0);
        chk("t6_rst_valid", ValidF, 0);
        tick(); lat = 0; reset = 1'b1; #3;
        chk("t6_boot_req", imem_bus.imem_req, 0);
        tick(); #3;
        chk("t6_refetch_addr", imem_bus.imem_addr, 32'h3000);
        chk("t6_refetch_valid", ValidF, 1);
        tick(); #3 chk("t6_pcf1", PCF, 32'h3004);
        tick();

        // Delivered stream, hand-derived
        exp_list = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014,
                     32'h3100, 32'h3104, 32'h3200, 32'h3204, 32'h3208, 32'h3200,
                     32'h3000, 32'h3004};
        chk("deliv_count", 32'(deliv_q.size()), 32'(exp_list.size()));
        for (int i = 0; i < exp_list.size(); i++) begin
            if (i < deliv_q.size()) chk($sformatf("deliv_%0d", i), deliv_q[i], exp_list[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
